// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy and threshold flags.
// Define SYNC_FIFO_ERR_CHK_EN to build in sticky overflow/underflow flags and their checks.
module sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                     clkIn,
  input  logic                     rstNIn,
  input  logic                     wrEnIn,
  input  logic [DATA_W-1:0]        wrDataIn,
  output logic                     fullOut,
  output logic                     almostFullOut,
  input  logic                     rdEnIn,
  output logic [DATA_W-1:0]        rdDataOut,
  output logic                     emptyOut,
  output logic                     almostEmptyOut,
  output logic [$clog2(DEPTH):0]   countOut,
  output logic                     overflowOut,
  output logic                     underflowOut
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          full_reg, full_next;
  logic          empty_reg, empty_next;
  logic          afull_reg, afull_next;
  logic          aempty_reg, aempty_next;
  logic          wr_acc, rd_acc;

  // Acceptance looks only at registered status, so a read never frees room for a same-cycle write.
  assign wr_acc = wrEnIn && !full_reg;
  assign rd_acc = rdEnIn && !empty_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg + CW'(wr_acc);
    rd_ptr_next = rd_ptr_reg + CW'(rd_acc);
    count_next  = wr_ptr_next - rd_ptr_next;
    full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    empty_next  = (wr_ptr_next == rd_ptr_next);
    afull_next  = (count_next >= CW'(AFULL_TH));
    aempty_next = (count_next <= CW'(AEMPTY_TH));
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
      afull_reg  <= afull_next;
      aempty_reg <= aempty_next;
    end
  end

  // Storage carries no reset; stale entries are hidden behind the empty gate on the read mux.
  always_ff @(posedge clkIn) begin
    if (wr_acc) begin
      mem[wr_ptr_reg[AW-1:0]] <= wrDataIn;
    end
  end

  assign rdDataOut      = empty_reg ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign fullOut        = full_reg;
  assign emptyOut       = empty_reg;
  assign almostFullOut  = afull_reg;
  assign almostEmptyOut = aempty_reg;
  assign countOut       = count_reg;

`ifdef SYNC_FIFO_ERR_CHK_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wrEnIn && full_reg)  overflow_reg  <= 1'b1;
      if (rdEnIn && empty_reg) underflow_reg <= 1'b1;
    end
  end

  assign overflowOut  = overflow_reg;
  assign underflowOut = underflow_reg;

`ifndef SYNTHESIS
  overflow_chk: assert property (@(posedge clkIn) disable iff (!rstNIn) !(wrEnIn && full_reg))
    else $warning("sync_fifo: write attempted while full");
  underflow_chk: assert property (@(posedge clkIn) disable iff (!rstNIn) !(rdEnIn && empty_reg))
    else $warning("sync_fifo: read attempted while empty");
`endif
`else
  assign overflowOut  = 1'b0;
  assign underflowOut = 1'b0;
`endif

endmodule
